// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM stage with a word RAM of configurable access latency, stalling upstream during multi-cycle accesses.
module mem_stage_access #(
    parameter int LATENCY = 2,
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MEM_M,
    input  logic [1:0]  WB_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] WriteData_M,
    input  logic [4:0]  WriteReg_M,
    output logic        stall_M,
    output logic [1:0]  WB_W,
    output logic [31:0] ReadData_W,
    output logic [31:0] ALUOut_W,
    output logic [4:0]  WriteReg_W,
    output logic        align_err_W
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int CW = $clog2(LATENCY + 1);
    localparam int LD = LATENCY > 1 ? LATENCY - 2 : 0;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic        cap_wr;
    logic [1:0]  cap_wb;
    logic [31:0] cap_alu, cap_data;
    logic [4:0]  cap_reg;
    logic [31:0] ram [2**AW];
    logic        memop, aligned, in_wait, start, done, sel_wr;
    logic [1:0]  sel_wb;
    logic [31:0] sel_alu, sel_data;
    logic [4:0]  sel_reg;
    logic [AW-1:0] idx;
    logic        unused_branch;
    assign unused_branch = MEM_M[2];
    always_comb begin
        memop    = MEM_M[1] | MEM_M[0];
        aligned  = memop && ALUOut_M[1:0] == 2'b00;
        in_wait  = state == WAIT;
        start    = !in_wait && aligned && LATENCY > 1;
        done     = in_wait ? cnt == '0 : aligned && LATENCY == 1;
        sel_wr   = in_wait ? cap_wr : MEM_M[0];
        sel_wb   = in_wait ? cap_wb : WB_M;
        sel_alu  = in_wait ? cap_alu : ALUOut_M;
        sel_data = in_wait ? cap_data : WriteData_M;
        sel_reg  = in_wait ? cap_reg : WriteReg_M;
        idx      = sel_alu[AW+1:2];
        stall_M  = !reset && (start || (in_wait && cnt != '0));
        state_n  = start ? WAIT : (in_wait && cnt == '0) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            WB_W        <= '0;
            ReadData_W  <= '0;
            ALUOut_W    <= '0;
            WriteReg_W  <= '0;
            align_err_W <= 1'b0;
        end else begin
            state       <= state_n;
            align_err_W <= !in_wait && memop && !aligned;
            if (done) begin
                WB_W       <= sel_wb;
                ReadData_W <= sel_wr ? '0 : ram[idx];
                ALUOut_W   <= sel_alu;
                WriteReg_W <= sel_reg;
            end else if (start || in_wait) begin
                WB_W       <= '0;
                ReadData_W <= '0;
                ALUOut_W   <= '0;
                WriteReg_W <= '0;
                cnt        <= start ? CW'(LD) : cnt - 1'b1;
            end else begin
                WB_W       <= memop ? 2'b00 : WB_M;
                ReadData_W <= '0;
                ALUOut_W   <= ALUOut_M;
                WriteReg_W <= WriteReg_M;
            end
        end
    end
    // RAM is never cleared; a reset on the completion edge suppresses the write
    always_ff @(posedge clk) begin
        if (start) begin
            cap_wr   <= MEM_M[0];
            cap_wb   <= WB_M;
            cap_alu  <= ALUOut_M;
            cap_data <= WriteData_M;
            cap_reg  <= WriteReg_M;
        end
        if (!reset && done && sel_wr)
            ram[idx] <= sel_data;
    end
endmodule
